reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_pkg.sv | 13 +
 rtl/reg_file_scoreboard.sv | 59 +++++
 rtl/reg_file_mp.sv | 68 ++++++
 tb/tb_reg_file_mp.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and default dimensions for the multi-port register file.
package reg_file_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam int DEF_XLEN  = 32;
   localparam int DEF_NREGS = 32;
   localparam int DEF_NRD   = 2;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-value bits plus the clear-sweep FSM that zeroes them one entry per cycle.
//   state | meaning
//   IDLE  | normal operation, writes clear pending, marks set it
//   CLEAR | sweep: entry cnt zeroed each cycle, busy high
module reg_file_scoreboard
   import reg_file_pkg::*;
#(
   parameter int NREGS = DEF_NREGS,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [AW-1:0]    wa,
   input  logic             mark,
   input  logic [AW-1:0]    ma,
   output logic             busy,
   output logic [AW-1:0]    cnt,
   output logic [NREGS-1:0] pending
);

   state_t state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         cnt   <= '0;
         busy  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               // mark is applied after the write so it wins on a shared address
               if (en && wa != '0)   pending[wa] <= 1'b0;
               if (mark && ma != '0) pending[ma] <= 1'b1;
               if (clr) begin
                  state <= CLEAR;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            CLEAR: begin
               pending[cnt] <= 1'b0;
               cnt          <= cnt + AW'(1);
               if (cnt == AW'(NREGS - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= CLEAR;
               cnt   <= '0;
               busy  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with hardwired x0 and operand-ready tracking.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int XLEN  = DEF_XLEN,
   parameter int NREGS = DEF_NREGS,
   parameter int NRD   = DEF_NRD,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CLR,
   input  logic              EN,
   input  logic [AW-1:0]     WA,
   input  logic [XLEN-1:0]   WD,
   input  logic              MARK,
   input  logic [AW-1:0]     MA,
   input  logic [NRD*AW-1:0] ADR,
   output logic [NRD*XLEN-1:0] RS,
   output logic [NRD-1:0]    RDY,
   output logic              BUSY
);

   logic [XLEN-1:0]  mem [NREGS];
   logic [AW-1:0]    cnt;
   logic [NREGS-1:0] pending;

   reg_file_scoreboard #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_sb (
      .clk     (CLK),
      .rst     (RST),
      .clr     (CLR),
      .en      (EN),
      .wa      (WA),
      .mark    (MARK),
      .ma      (MA),
      .busy    (BUSY),
      .cnt     (cnt),
      .pending (pending)
   );

   always_ff @(posedge CLK) begin
      if (!RST) begin
         if (BUSY)
            mem[cnt] <= '0;
         else if (EN && WA != '0)
            mem[WA] <= WD;
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] a;
      logic          hit;

      assign a = ADR[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
      assign hit = !BUSY && EN && WA != '0 && WA == a;
`else
      assign hit = 1'b0;
`endif
      assign RS[i*XLEN +: XLEN] = (BUSY || a == '0) ? '0 : (hit ? WD : mem[a]);
      assign RDY[i] = BUSY ? 1'b0 : (hit ? !(MARK && MA == a) : !pending[a]);
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: default build plus a 16-bit, 8-entry, 3-port instance.
module tb_reg_file_mp;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, clr, en, mark;
   logic [4:0]  wa, ma;
   logic [31:0] wd;
   logic [9:0]  adr;
   logic [63:0] rs;
   logic [1:0]  rdy;
   logic        busy;

   logic        clr2, en2, mark2;
   logic [2:0]  wa2, ma2;
   logic [15:0] wd2;
   logic [8:0]  adr2;
   logic [47:0] rs2;
   logic [2:0]  rdy2;
   logic        busy2;

   reg_file_mp dut (
      .CLK(clk), .RST(rst), .CLR(clr), .EN(en), .WA(wa), .WD(wd),
      .MARK(mark), .MA(ma), .ADR(adr), .RS(rs), .RDY(rdy), .BUSY(busy)
   );

   reg_file_mp #(.XLEN(16), .NREGS(8), .NRD(3)) dut2 (
      .CLK(clk), .RST(rst), .CLR(clr2), .EN(en2), .WA(wa2), .WD(wd2),
      .MARK(mark2), .MA(ma2), .ADR(adr2), .RS(rs2), .RDY(rdy2), .BUSY(busy2)
   );

   typedef struct {
      int          d;
      int          p;
      logic [31:0] rs;
      logic        rdy;
      logic        busy;
      string       nm;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic expect_rd(input int d, input int p, input logic [31:0] r,
                            input logic y, input logic b, input string nm);
      exp_t e;
      e.d = d; e.p = p; e.rs = r; e.rdy = y; e.busy = b; e.nm = nm;
      q.push_back(e);
   endtask

   task automatic chk_busy(input logic b, input string nm);
      n_chk++;
      if (busy !== b) begin
         n_fail++;
         $display("FAIL %s: busy=%b, expected %b", nm, busy, b);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] ars;
      logic        ardy, ab;
      while (q.size() > 0) begin
         e = q.pop_front();
         if (e.d == 0) begin
            ars  = rs[e.p*32 +: 32];
            ardy = rdy[e.p];
            ab   = busy;
         end else begin
            ars  = {16'h0, rs2[e.p*16 +: 16]};
            ardy = rdy2[e.p];
            ab   = busy2;
         end
         n_chk++;
         if (ars !== e.rs || ardy !== e.rdy || ab !== e.busy) begin
            n_fail++;
            $display("FAIL %s: dut%0d port%0d got rs=%h rdy=%b busy=%b, expected rs=%h rdy=%b busy=%b",
                     e.nm, e.d, e.p, ars, ardy, ab, e.rs, e.rdy, e.busy);
         end
      end
   end

   initial begin
      rst = 1'b1; clr = 1'b0; en = 1'b0; mark = 1'b0;
      wa = '0; ma = '0; wd = '0; adr = {5'd3, 5'd0};
      clr2 = 1'b0; en2 = 1'b0; mark2 = 1'b0; wa2 = '0; ma2 = '0; wd2 = '0;
      adr2 = {3'd1, 3'd2, 3'd1};
      cyc();
      chk_busy(1'b1, "rst_entry");
      rst = 1'b0;

      // reset sweep: 32 busy cycles on the default instance, 8 on the small one
      for (int k = 0; k < 32; k++) begin
         expect_rd(0, 0, 32'd0, 1'b0, 1'b1, "rst_sweep_p0");
         expect_rd(0, 1, 32'd0, 1'b0, 1'b1, "rst_sweep_p1");
         if (k < 8) expect_rd(1, 0, 32'd0, 1'b0, 1'b1, "rst_sweep_small");
         else       expect_rd(1, 0, 32'd0, 1'b1, 1'b0, "rst_done_small");
         cyc();
      end
      chk_busy(1'b0, "rst_expired");
      expect_rd(0, 0, 32'd0, 1'b1, 1'b0, "rst_done_x0");
      expect_rd(0, 1, 32'd0, 1'b1, 1'b0, "rst_done_x3");
      cyc();

      // write 80 to x4
      en = 1'b1; wa = 5'd4; wd = 32'd80; adr = {5'd4, 5'd4};
      expect_rd(0, 0, BYP ? 32'd80 : 32'd0, 1'b1, 1'b0, "wr4_same_p0");
      expect_rd(0, 1, BYP ? 32'd80 : 32'd0, 1'b1, 1'b0, "wr4_same_p1");
      cyc();
      en = 1'b0;
      expect_rd(0, 0, 32'd80, 1'b1, 1'b0, "rd4_p0");
      expect_rd(0, 1, 32'd80, 1'b1, 1'b0, "rd4_p1");
      cyc();

      // x0 write ignored
      en = 1'b1; wa = 5'd0; wd = 32'd25; adr = {5'd4, 5'd0};
      expect_rd(0, 0, 32'd0, 1'b1, 1'b0, "wr0_same");
      cyc();
      en = 1'b0;
      expect_rd(0, 0, 32'd0, 1'b1, 1'b0, "rd0");
      expect_rd(0, 1, 32'd80, 1'b1, 1'b0, "rd4_after_x0");
      cyc();

      // pending tracking on x7
      mark = 1'b1; ma = 5'd7; adr = {5'd4, 5'd7};
      expect_rd(0, 0, 32'd0, 1'b1, 1'b0, "mark7_same");
      cyc();
      mark = 1'b0;
      expect_rd(0, 0, 32'd0, 1'b0, 1'b0, "mark7_pending");
      cyc();
      en = 1'b1; wa = 5'd7; wd = 32'd140;
      expect_rd(0, 0, BYP ? 32'd140 : 32'd0, BYP, 1'b0, "wr7_same");
      cyc();
      en = 1'b0;
      expect_rd(0, 0, 32'd140, 1'b1, 1'b0, "wr7_ready");
      cyc();
      en = 1'b1; wa = 5'd7; wd = 32'd141; mark = 1'b1; ma = 5'd7;
      expect_rd(0, 0, BYP ? 32'd141 : 32'd140, BYP ? 1'b0 : 1'b1, 1'b0, "wr_mark7_same");
      cyc();
      en = 1'b0; mark = 1'b0;
      expect_rd(0, 0, 32'd141, 1'b0, 1'b0, "wr_mark7_after");
      cyc();

      // clear sweep after writes to x4 and x8
      en = 1'b1; wa = 5'd8; wd = 32'd99;
      cyc();
      en = 1'b0; clr = 1'b1; adr = {5'd8, 5'd4};
      expect_rd(0, 0, 32'd80, 1'b1, 1'b0, "pre_clr_x4");
      expect_rd(0, 1, 32'd99, 1'b1, 1'b0, "pre_clr_x8");
      cyc();
      en = 1'b1; wa = 5'd5; wd = 32'd55; mark = 1'b1; ma = 5'd6;
      for (int k = 0; k < 32; k++) begin
         clr = (k < 31);
         expect_rd(0, 0, 32'd0, 1'b0, 1'b1, "clr_sweep_p0");
         expect_rd(0, 1, 32'd0, 1'b0, 1'b1, "clr_sweep_p1");
         cyc();
      end
      clr = 1'b0; en = 1'b0; mark = 1'b0;
      expect_rd(0, 0, 32'd0, 1'b1, 1'b0, "post_clr_x4");
      expect_rd(0, 1, 32'd0, 1'b1, 1'b0, "post_clr_x8");
      cyc();
      adr = {5'd6, 5'd5};
      expect_rd(0, 0, 32'd0, 1'b1, 1'b0, "no_trace_x5");
      expect_rd(0, 1, 32'd0, 1'b1, 1'b0, "no_trace_x6");
      adr2 = {3'd1, 3'd2, 3'd1};
      cyc();
      adr = {5'd7, 5'd4};
      expect_rd(0, 1, 32'd0, 1'b1, 1'b0, "post_clr_x7");
      cyc();

      // reset in the middle of a sweep restarts it
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      for (int k = 0; k < 10; k++) begin
         expect_rd(0, 0, 32'd0, 1'b0, 1'b1, "sweep_pre_rst");
         cyc();
      end
      rst = 1'b1;
      expect_rd(0, 0, 32'd0, 1'b0, 1'b1, "sweep_at_rst");
      cyc();
      rst = 1'b0;
      for (int k = 0; k < 32; k++) begin
         expect_rd(0, 0, 32'd0, 1'b0, 1'b1, "sweep_restart");
         cyc();
      end
      chk_busy(1'b0, "sweep_restart_expired");
      expect_rd(0, 0, 32'd0, 1'b1, 1'b0, "sweep_restart_done");
      cyc();

      // small instance: three ports reading x1, x2, x1
      en2 = 1'b1; wa2 = 3'd1; wd2 = 16'h1234;
      cyc();
      wa2 = 3'd2; wd2 = 16'hBEEF;
      cyc();
      en2 = 1'b0;
      expect_rd(1, 0, 32'h1234, 1'b1, 1'b0, "small_p0_x1");
      expect_rd(1, 1, 32'hBEEF, 1'b1, 1'b0, "small_p1_x2");
      expect_rd(1, 2, 32'h1234, 1'b1, 1'b0, "small_p2_x1");
      cyc();

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
